// File: rtl/wb_adder_initiator_if.sv
// Wishbone classic bus bundle between the adder initiator and the adder
// peripheral's bus responder.
//   cyc, stb, we, sel, adr, dat_w : initiator -> responder
//   dat_r, ack, err               : responder -> initiator
interface wb_adder_initiator_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_adder_initiator.sv
// Wishbone classic initiator that exercises the 16-bit Sklansky adder
// peripheral. One start request does the following:
//   - writes A, B and carry-in,
//   - reads back the 17-bit sum,
//   - compares the sum against a locally computed reference.
//
// Ports:
//   wb_clk_i, wb_rst_n_i : clock, asynchronous active-low reset
//   start_i              : start request, accepted only in IDLE
//   op_a_i, op_b_i       : operands, captured on accepted start
//   op_cin_i             : carry-in, captured on accepted start
//   busy_o               : high from accepted start through the done_o cycle
//   done_o               : one-cycle end-of-operation pulse
//   result_o             : sum read back, {carry, sum[15:0]}
//   mismatch_o           : readback differs from the reference
//   abort_o              : operation ended by timeout or bus error
//   wbm                  : Wishbone initiator port (all outputs registered)
//
// State table:
//   IDLE  | waiting for start_i
//   WR_A  | write operand A to BASE_ADDR+0x0
//   GAP_A | bus idle for one cycle
//   WR_B  | write operand B to BASE_ADDR+0x4
//   GAP_B | bus idle for one cycle
//   WR_C  | write carry-in to BASE_ADDR+0x8
//   GAP_C | bus idle for one cycle
//   RD_S  | read the sum from BASE_ADDR+0xC
//   FIN   | first cycle: quiet; second cycle: done_o pulse, then IDLE
module wb_adder_initiator #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    input  logic                        start_i,
    input  logic [15:0]                 op_a_i,
    input  logic [15:0]                 op_b_i,
    input  logic                        op_cin_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [16:0]                 result_o,
    output logic                        mismatch_o,
    output logic                        abort_o,
    wb_adder_initiator_if.master        wbm
);

    typedef enum logic [3:0] {
        IDLE, WR_A, GAP_A, WR_B, GAP_B, WR_C, GAP_C, RD_S, FIN
    } state_t;

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        cin_q;
    logic [16:0] ref_q;
    logic [7:0]  tmo_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    // Upper readback bits carry no information for a 17-bit sum.
    logic unused_dat_hi;
    assign unused_dat_hi = ^wbm.dat_r[31:17];

    assign wbm.cyc   = cyc_q;
    assign wbm.stb   = stb_q;
    assign wbm.we    = we_q;
    assign wbm.sel   = sel_q;
    assign wbm.adr   = adr_q;
    assign wbm.dat_w = dat_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            ref_q      <= '0;
            tmo_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            mismatch_o <= 1'b0;
            abort_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q        <= op_a_i;
                        b_q        <= op_b_i;
                        cin_q      <= op_cin_i;
                        ref_q      <= {1'b0, op_a_i} + {1'b0, op_b_i} + {16'h0, op_cin_i};
                        mismatch_o <= 1'b0;
                        abort_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        we_q       <= 1'b1;
                        sel_q      <= 4'hF;
                        adr_q      <= BASE_ADDR;
                        dat_q      <= {16'h0, op_a_i};
                        tmo_q      <= TMO_LOAD;
                        state      <= WR_A;
                    end
                end
                WR_A, WR_B, WR_C, RD_S: begin
                    // A transaction ends on err, ack or an expired timer; err
                    // takes priority over a simultaneous ack.
                    if (wbm.err || wbm.ack || tmo_q == 8'd0) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= '0;
                        adr_q <= '0;
                        dat_q <= '0;
                        if (wbm.err || !wbm.ack) begin
                            abort_o <= 1'b1;
                            state   <= FIN;
                        end else begin
                            case (state)
                                WR_A:    state <= GAP_A;
                                WR_B:    state <= GAP_B;
                                WR_C:    state <= GAP_C;
                                default: begin
                                    result_o   <= wbm.dat_r[16:0];
                                    mismatch_o <= (wbm.dat_r[16:0] != ref_q);
                                    state      <= FIN;
                                end
                            endcase
                        end
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                GAP_A: begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    we_q  <= 1'b1;
                    sel_q <= 4'hF;
                    adr_q <= BASE_ADDR + 32'h4;
                    dat_q <= {16'h0, b_q};
                    tmo_q <= TMO_LOAD;
                    state <= WR_B;
                end
                GAP_B: begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    we_q  <= 1'b1;
                    sel_q <= 4'hF;
                    adr_q <= BASE_ADDR + 32'h8;
                    dat_q <= {31'h0, cin_q};
                    tmo_q <= TMO_LOAD;
                    state <= WR_C;
                end
                GAP_C: begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    we_q  <= 1'b0;
                    sel_q <= 4'hF;
                    adr_q <= BASE_ADDR + 32'hC;
                    dat_q <= '0;
                    tmo_q <= TMO_LOAD;
                    state <= RD_S;
                end
                FIN: begin
                    // Two cycles in FIN so a start coinciding with done_o is
                    // still seen outside IDLE and ignored.
                    if (!done_o) begin
                        done_o <= 1'b1;
                    end else begin
                        done_o <= 1'b0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_adder_initiator.sv
module tb_wb_adder_initiator;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        op_cin = 1'b0;
    logic        busy;
    logic        done;
    logic [16:0] result;
    logic        mism;
    logic        abrt;

    int n_checks = 0;
    int n_fail = 0;

    wb_adder_initiator_if bus();

    wb_adder_initiator #(.BASE_ADDR(BASE), .TIMEOUT(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .op_cin_i   (op_cin),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .mismatch_o (mism),
        .abort_o    (abrt),
        .wbm        (bus)
    );

    always #5 clk = ~clk;

    // Responder model
    int          ws = 0;
    int          wcnt = 0;
    logic [31:0] rd_val = '0;
    bit          noack_en = 0;
    logic [31:0] noack_adr = '0;
    bit          err_en = 0;
    logic [31:0] err_adr = '0;

    always @(negedge clk) begin
        if (bus.stb) begin
            if (err_en && bus.adr == err_adr) begin
                bus.ack = 1'b1;
                bus.err = 1'b1;
            end else if (noack_en && bus.adr == noack_adr) begin
                bus.ack = 1'b0;
            end else if (wcnt == ws) begin
                bus.ack   = 1'b1;
                bus.dat_r = bus.we ? 32'h0 : rd_val;
            end else begin
                wcnt++;
            end
        end else begin
            bus.ack   = 1'b0;
            bus.err   = 1'b0;
            bus.dat_r = '0;
            wcnt      = 0;
        end
    end

    // Transaction log: one entry per strobe run
    logic [31:0] t_adr[$];
    logic [31:0] t_dat[$];
    logic        t_we[$];
    int          t_len[$];
    int          run_len = 0;
    logic        prev_stb = 1'b0;
    logic [31:0] cur_adr, cur_dat;
    logic        cur_we;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (bus.stb && !prev_stb) begin
            run_len = 1;
            cur_adr = bus.adr;
            cur_dat = bus.dat_w;
            cur_we  = bus.we;
        end else if (bus.stb) begin
            run_len++;
        end else if (prev_stb) begin
            t_adr.push_back(cur_adr);
            t_dat.push_back(cur_dat);
            t_we.push_back(cur_we);
            t_len.push_back(run_len);
        end
        prev_stb = bus.stb;
        if (done) done_cnt++;
    end

    task automatic clear_log();
        t_adr.delete();
        t_dat.delete();
        t_we.delete();
        t_len.delete();
    endtask

    // Pulses start for one cycle and returns the cycle index of done_o
    // (stb of WR_A is cycle 1), or -1 if done never came.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, output int cyc);
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; start = 1'b1;
        cyc = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, mism, abrt} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done, mism, abrt});
        end
        n_checks++;
        if (result !== 17'h0) begin
            n_fail++; $display("FAIL reset_result got %h want 00000", result);
        end
        n_checks++;
        if ({bus.cyc, bus.stb, bus.we, bus.sel} !== 7'b0 || bus.adr !== 32'h0 || bus.dat_w !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got cyc%b stb%b we%b sel%h adr%h dat%h want all 0",
                               bus.cyc, bus.stb, bus.we, bus.sel, bus.adr, bus.dat_w);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int cyc;
        logic [31:0] ea[4] = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC};
        logic [31:0] ed[4] = '{32'h1234, 32'h4321, 32'h0, 32'h0};
        logic        ew[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        ws = 0; rd_val = 32'hABCC_5555; clear_log();
        run_op(16'h1234, 16'h4321, 1'b0, cyc);
        n_checks++;
        if (cyc !== 9) begin n_fail++; $display("FAIL zw_done_cycle got %0d want 9", cyc); end
        n_checks++;
        if (result !== 17'h05555 || mism !== 1'b0 || abrt !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zw_result got %h mism%b abort%b busy%b want 05555 0 0 1", result, mism, abrt, busy);
        end
        n_checks++;
        if (t_adr.size() !== 4) begin
            n_fail++; $display("FAIL zw_txn_count got %0d want 4", t_adr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (t_adr[i] !== ea[i] || t_dat[i] !== ed[i] || t_we[i] !== ew[i] || t_len[i] !== 1) begin
                    n_fail++; $display("FAIL zw_txn%0d got adr%h dat%h we%b len%0d want adr%h dat%h we%b len1",
                                       i, t_adr[i], t_dat[i], t_we[i], t_len[i], ea[i], ed[i], ew[i]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL zw_after_done got busy%b done%b want 0 0", busy, done);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        ws = 3; rd_val = 32'h0001_FFFF; clear_log();
        run_op(16'hFFFF, 16'hFFFF, 1'b1, cyc);
        n_checks++;
        if (cyc !== 21) begin n_fail++; $display("FAIL ws_done_cycle got %0d want 21", cyc); end
        n_checks++;
        if (result !== 17'h1FFFF || mism !== 1'b0 || abrt !== 1'b0) begin
            n_fail++; $display("FAIL ws_result got %h mism%b abort%b want 1ffff 0 0", result, mism, abrt);
        end
        n_checks++;
        if (t_len.size() !== 4) begin
            n_fail++; $display("FAIL ws_txn_count got %0d want 4", t_len.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (t_len[i] !== 4 || t_adr[i] !== BASE + 32'(4 * i)) begin
                    n_fail++; $display("FAIL ws_txn%0d got len%0d adr%h want len4 adr%h", i, t_len[i], t_adr[i], BASE + 32'(4 * i));
                end
            end
            n_checks++;
            if (t_dat[2] !== 32'h1) begin n_fail++; $display("FAIL ws_cin_data got %h want 00000001", t_dat[2]); end
        end
        ws = 0;
    endtask

    task automatic test_mismatch();
        int cyc;
        rd_val = 32'h0000_5554; clear_log();
        run_op(16'h1234, 16'h4321, 1'b0, cyc);
        n_checks++;
        if (cyc !== 9 || mism !== 1'b1 || result !== 17'h05554 || abrt !== 1'b0) begin
            n_fail++; $display("FAIL mm_flag got cyc%0d mism%b res%h abort%b want 9 1 05554 0", cyc, mism, result, abrt);
        end
        @(negedge clk);
        n_checks++;
        if (mism !== 1'b1) begin n_fail++; $display("FAIL mm_hold got %b want 1", mism); end
        rd_val = 32'h0000_0004;
        @(negedge clk);
        op_a = 16'h0001; op_b = 16'h0002; op_cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (mism !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mm_clear got mism%b busy%b want 0 1", mism, busy);
        end
        cyc = -1;
        for (int n = 2; n <= 100; n++) begin
            @(negedge clk);
            if (done) begin cyc = n; break; end
        end
        n_checks++;
        if (cyc !== 9 || result !== 17'h00004 || mism !== 1'b0) begin
            n_fail++; $display("FAIL mm_followup got cyc%0d res%h mism%b want 9 00004 0", cyc, result, mism);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        noack_en = 1; noack_adr = BASE + 32'h4; clear_log();
        run_op(16'h00AA, 16'h0055, 1'b0, cyc);
        n_checks++;
        if (cyc !== 20 || abrt !== 1'b1 || result !== 17'h00004 || mism !== 1'b0) begin
            n_fail++; $display("FAIL to_done got cyc%0d abort%b res%h mism%b want 20 1 00004 0", cyc, abrt, result, mism);
        end
        n_checks++;
        if (t_adr.size() !== 2) begin
            n_fail++; $display("FAIL to_txn_count got %0d want 2", t_adr.size());
        end else begin
            n_checks++;
            if (t_adr[1] !== BASE + 32'h4 || t_len[1] !== 16) begin
                n_fail++; $display("FAIL to_stb_len got adr%h len%0d want %h 16", t_adr[1], t_len[1], BASE + 32'h4);
            end
        end
        noack_en = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_err();
        int stb_seen = 0;
        err_en = 1; err_adr = BASE; clear_log();
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = 16'h9999; start = 1'b1;
        n_checks++;
        if (busy !== 1'b1 || bus.stb !== 1'b1) begin
            n_fail++; $display("FAIL err_busy got busy%b stb%b want 1 1", busy, bus.stb);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || abrt !== 1'b1 || result !== 17'h00004) begin
            n_fail++; $display("FAIL err_done got done%b abort%b res%h want 1 1 00004", done, abrt, result);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || abrt !== 1'b1) begin
            n_fail++; $display("FAIL err_after got busy%b done%b abort%b want 0 0 1", busy, done, abrt);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.stb || busy) stb_seen++;
        end
        n_checks++;
        if (stb_seen !== 0 || t_adr.size() !== 1) begin
            n_fail++; $display("FAIL err_no_more got active%0d txns%0d want 0 1", stb_seen, t_adr.size());
        end
        err_en = 0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int dc;
        bit found = 0;
        ws = 5; rd_val = 32'h0000_0100;
        @(negedge clk);
        op_a = 16'h00FF; op_b = 16'h0001; op_cin = 1'b0; start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.stb && bus.adr == BASE + 32'hC && run_len >= 2) begin found = 1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rm_reach_rd got 0 want 1"); end
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cyc !== 1'b0 || bus.stb !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rm_drop got cyc%b stb%b busy%b want 0 0 0", bus.cyc, bus.stb, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt !== dc || done !== 1'b0 || result !== 17'h0) begin
            n_fail++; $display("FAIL rm_no_done got dones%0d res%h want %0d 00000", done_cnt, result, dc);
        end
        ws = 0; clear_log();
        run_op(16'h00FF, 16'h0001, 1'b0, cyc);
        n_checks++;
        if (cyc !== 9 || result !== 17'h00100 || mism !== 1'b0 || abrt !== 1'b0 || t_adr.size() !== 4) begin
            n_fail++; $display("FAIL rm_fresh got cyc%0d res%h mism%b abort%b txns%0d want 9 00100 0 0 4",
                               cyc, result, mism, abrt, t_adr.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_mismatch();
        test_timeout();
        test_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
